// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_pkg
// Description : Shared phase encoding, FSM states and field widths for the
//               PPG phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_pkg;

    localparam int GAIN_W = 4;
    localparam int DC_W   = 7;

    localparam logic [1:0] CH_RED = 2'd0;
    localparam logic [1:0] CH_IR  = 2'd1;
    localparam logic [1:0] CH_AMB = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic amb);
        case (phase)
            CH_RED:  return CH_IR;
            CH_IR:   return amb ? CH_AMB : CH_RED;
            default: return CH_RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppg_sample_reg.sv
`default_nettype none
// ============================================================================
// Module      : ppg_sample_reg
// Description : Single-entry valid/ready sample holding register with a
//               sticky overrun flag for overwritten, unaccepted samples.
// Revision    : 1.0 - initial release
// ============================================================================
module ppg_sample_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cap,
    input  logic [1:0]        i_chan,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [1:0]        o_chan,
    output logic [DATA_W-1:0] o_data,
    output logic              o_overrun
);

    logic              r_valid;
    logic [1:0]        r_chan;
    logic [DATA_W-1:0] r_data;
    logic              r_overrun;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_chan    <= 2'd0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_cap) begin
                // A capture coinciding with acceptance is a clean hand-over
                r_valid <= 1'b1;
                r_chan  <= i_chan;
                r_data  <= i_data;
                if (r_valid && !i_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_chan    = r_chan;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/ppg_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ppg_phase_scheduler
// Description : Time-division RED / IR / AMBIENT sampling scheduler driving
//               LEDs, front-end settings and the ADC start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ppg_phase_scheduler
    import pulse_pkg::*;
#(
    parameter int SETTLE_CYC = 8,
    parameter int PHASE_CYC  = 64,
    parameter int ADC_TMO    = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              amb_en,
    input  logic [3:0]        red_gain,
    input  logic [6:0]        red_dc,
    input  logic [3:0]        ir_gain,
    input  logic [6:0]        ir_dc,
    output logic              led_red,
    output logic              led_ir,
    output logic [3:0]        pga_gain,
    output logic [6:0]        dc_comp,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              smp_valid,
    output logic [1:0]        smp_chan,
    output logic [DATA_W-1:0] smp_data,
    input  logic              smp_ready,
    output logic              overrun,
    output logic              adc_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(PHASE_CYC);
    // phase_cnt is 0 in SETUP, so SETTLE spans 1..SETTLE_CYC and adc_start lands on SETTLE_CYC+1
    localparam logic [CNT_W-1:0] c_settle_end = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] c_tmo_end    = CNT_W'(SETTLE_CYC + 1 + ADC_TMO);
    localparam logic [CNT_W-1:0] c_phase_end  = CNT_W'(PHASE_CYC - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_phase;
    logic [1:0]         w_phase_nxt;
    logic [CNT_W-1:0]   r_phase_cnt;
    logic               w_cap;
    logic               w_tmo;

    logic [GAIN_W-1:0]  r_sh_red_gain;
    logic [DC_W-1:0]    r_sh_red_dc;
    logic [GAIN_W-1:0]  r_sh_ir_gain;
    logic [DC_W-1:0]    r_sh_ir_dc;
    logic               r_sh_amb;

    logic               r_led_red;
    logic               r_led_ir;
    logic [GAIN_W-1:0]  r_pga_gain;
    logic [DC_W-1:0]    r_dc_comp;
    logic               r_adc_start;
    logic               r_adc_err;
    logic               r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cap       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = CH_RED;
                if (enable) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_phase_cnt == c_settle_end) begin
                    w_state_nxt = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (adc_done) begin
                    w_cap       = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (r_phase_cnt == c_tmo_end) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_phase_cnt == c_phase_end) begin
                    w_phase_nxt = next_phase(r_phase, r_sh_amb);
                    w_state_nxt = enable ? ST_SETUP : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase       <= CH_RED;
            r_phase_cnt   <= '0;
            r_sh_red_gain <= '0;
            r_sh_red_dc   <= '0;
            r_sh_ir_gain  <= '0;
            r_sh_ir_dc    <= '0;
            r_sh_amb      <= 1'b0;
            r_led_red     <= 1'b0;
            r_led_ir      <= 1'b0;
            r_pga_gain    <= '0;
            r_dc_comp     <= '0;
            r_adc_start   <= 1'b0;
            r_adc_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_phase_cnt <= (w_state_nxt == ST_SETUP || w_state_nxt == ST_IDLE) ?
                           '0 : r_phase_cnt + CNT_W'(1);

            // Frame settings are frozen on the edge that opens a RED SETUP
            if (w_state_nxt == ST_SETUP && w_phase_nxt == CH_RED) begin
                r_sh_red_gain <= red_gain;
                r_sh_red_dc   <= red_dc;
                r_sh_ir_gain  <= ir_gain;
                r_sh_ir_dc    <= ir_dc;
                r_sh_amb      <= amb_en;
            end

            if (r_state == ST_SETUP) begin
                case (r_phase)
                    CH_RED: begin
                        r_led_red  <= 1'b1;
                        r_led_ir   <= 1'b0;
                        r_pga_gain <= r_sh_red_gain;
                        r_dc_comp  <= r_sh_red_dc;
                    end
                    CH_IR: begin
                        r_led_red  <= 1'b0;
                        r_led_ir   <= 1'b1;
                        r_pga_gain <= r_sh_ir_gain;
                        r_dc_comp  <= r_sh_ir_dc;
                    end
                    default: begin
                        r_led_red  <= 1'b0;
                        r_led_ir   <= 1'b0;
                        r_pga_gain <= r_sh_ir_gain;
                        r_dc_comp  <= r_sh_ir_dc;
                    end
                endcase
            end else if (w_state_nxt == ST_IDLE) begin
                r_led_red <= 1'b0;
                r_led_ir  <= 1'b0;
            end

            r_adc_start <= (r_state == ST_SETTLE) && (w_state_nxt == ST_CONVERT);
            r_adc_err   <= r_adc_err | w_tmo;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    ppg_sample_reg #(
        .DATA_W (DATA_W)
    ) u_sample_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cap     (w_cap),
        .i_chan    (r_phase),
        .i_data    (adc_data),
        .i_ready   (smp_ready),
        .o_valid   (smp_valid),
        .o_chan    (smp_chan),
        .o_data    (smp_data),
        .o_overrun (overrun)
    );

    assign led_red   = r_led_red;
    assign led_ir    = r_led_ir;
    assign pga_gain  = r_pga_gain;
    assign dc_comp   = r_dc_comp;
    assign adc_start = r_adc_start;
    assign adc_err   = r_adc_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ppg_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppg_phase_scheduler
// Description : Directed self-checking bench for ppg_phase_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppg_phase_scheduler;

    localparam int SETTLE_CYC = 4;
    localparam int PHASE_CYC  = 32;
    localparam int ADC_TMO    = 16;
    localparam int DATA_W     = 8;
    localparam int N_CYC      = 372;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              amb_en;
    logic [3:0]        red_gain;
    logic [6:0]        red_dc;
    logic [3:0]        ir_gain;
    logic [6:0]        ir_dc;
    logic              led_red;
    logic              led_ir;
    logic [3:0]        pga_gain;
    logic [6:0]        dc_comp;
    logic              adc_start;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              smp_valid;
    logic [1:0]        smp_chan;
    logic [DATA_W-1:0] smp_data;
    logic              smp_ready;
    logic              overrun;
    logic              adc_err;
    logic              busy;

    typedef struct packed {
        logic       led_red;
        logic       led_ir;
        logic [3:0] pga;
        logic [6:0] dc;
        logic       adc_start;
        logic       valid;
        logic [1:0] chan;
        logic [7:0] data;
        logic       overrun;
        logic       adc_err;
        logic       busy;
    } obs_t;

    obs_t cur;
    obs_t rec [0:N_CYC-1];
    int   n_tests = 0;
    int   n_fail  = 0;

    assign cur = {led_red, led_ir, pga_gain, dc_comp, adc_start, smp_valid,
                  smp_chan, smp_data, overrun, adc_err, busy};

    always #5 clk = ~clk;

    ppg_phase_scheduler #(
        .SETTLE_CYC (SETTLE_CYC),
        .PHASE_CYC  (PHASE_CYC),
        .ADC_TMO    (ADC_TMO),
        .DATA_W     (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .amb_en    (amb_en),
        .red_gain  (red_gain),
        .red_dc    (red_dc),
        .ir_gain   (ir_gain),
        .ir_dc     (ir_dc),
        .led_red   (led_red),
        .led_ir    (led_ir),
        .pga_gain  (pga_gain),
        .dc_comp   (dc_comp),
        .adc_start (adc_start),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .smp_valid (smp_valid),
        .smp_chan  (smp_chan),
        .smp_data  (smp_data),
        .smp_ready (smp_ready),
        .overrun   (overrun),
        .adc_err   (adc_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shorthand for the LED + front-end setting bundle of one recorded cycle
    function automatic logic [31:0] afe(input obs_t o);
        return 32'({o.led_red, o.led_ir, o.pga, o.dc});
    endfunction

    function automatic logic [31:0] smp(input obs_t o);
        return 32'({o.valid, o.chan, o.data, o.overrun});
    endfunction

    initial begin
        int         pend;
        logic       mute;
        logic [7:0] dval;
        int         n_red, n_ir, n_off, n_val;

        rst_n = 1'b0; enable = 1'b0; amb_en = 1'b0;
        red_gain = 4'd5; red_dc = 7'd40; ir_gain = 4'd7; ir_dc = 7'd22;
        adc_done = 1'b0; adc_data = '0; smp_ready = 1'b1;
        pend = 0; mute = 1'b0; dval = 8'h10;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(cur), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Cycle 0 is the first RED SETUP; ADC answers 3 cycles after adc_start
        for (int k = 0; k < N_CYC; k++) begin
            @(posedge clk);
            #1;
            rec[k]   = cur;
            adc_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    adc_done = 1'b1;
                    adc_data = dval;
                    dval     = dval + 8'h11;
                end
            end
            if (cur.adc_start && !mute) pend = 3;
            case (k)
                100: amb_en    = 1'b1;
                170: red_gain  = 4'd9;
                190: smp_ready = 1'b0;
                232: smp_ready = 1'b1;
                240: smp_ready = 1'b0;
                300: smp_ready = 1'b1;
                310: mute      = 1'b1;
                345: mute      = 1'b0;
                346: begin adc_done = 1'b1; adc_data = 8'hEE; end
                354: rst_n     = 1'b0;
                356: rst_n     = 1'b1;
                default: ;
            endcase
        end

        // RED/IR alternation without AMBIENT
        check("setup_busy_leds", 32'({rec[0].busy, rec[0].led_red, rec[0].led_ir}), 32'b100);
        check("red_afe", afe(rec[1]), 32'({1'b1, 1'b0, 4'd5, 7'd40}));
        check("red_last_cycle", 32'({rec[32].led_red, rec[32].led_ir}), 32'b10);
        check("ir_afe", afe(rec[33]), 32'({1'b0, 1'b1, 4'd7, 7'd22}));
        check("red_again", 32'({rec[65].led_red, rec[65].led_ir}), 32'b10);
        check("adc_start_k4", 32'(rec[4].adc_start), 32'd0);
        check("adc_start_k5", 32'(rec[5].adc_start), 32'd1);
        check("adc_start_k6", 32'(rec[6].adc_start), 32'd0);
        check("adc_start_k37", 32'(rec[37].adc_start), 32'd1);
        check("adc_start_k69", 32'(rec[69].adc_start), 32'd1);
        check("smp_k9", smp(rec[9]), 32'({1'b1, 2'd0, 8'h10, 1'b0}));
        check("smp_k10_drop", 32'(rec[10].valid), 32'd0);
        check("smp_k41", smp(rec[41]), 32'({1'b1, 2'd1, 8'h21, 1'b0}));
        check("smp_k73", smp(rec[73]), 32'({1'b1, 2'd0, 8'h32, 1'b0}));
        check("smp_k105", smp(rec[105]), 32'({1'b1, 2'd1, 8'h43, 1'b0}));
        n_red = 0; n_ir = 0; n_off = 0;
        for (int k = 1; k <= 128; k++) begin
            if (rec[k].led_red) n_red++;
            if (rec[k].led_ir)  n_ir++;
        end
        check("red_cycles_a", 32'(n_red), 32'd64);
        check("ir_cycles_a", 32'(n_ir), 32'd64);

        // Frame with AMBIENT; red_gain change mid-IR only lands at the next RED SETUP
        n_red = 0; n_ir = 0;
        for (int k = 129; k <= 224; k++) begin
            if (rec[k].led_red) n_red++;
            if (rec[k].led_ir)  n_ir++;
            if (!rec[k].led_red && !rec[k].led_ir) n_off++;
        end
        check("red_cycles_b", 32'(n_red), 32'd32);
        check("ir_cycles_b", 32'(n_ir), 32'd32);
        check("amb_cycles_b", 32'(n_off), 32'd32);
        check("red_afe_b", afe(rec[129]), 32'({1'b1, 1'b0, 4'd5, 7'd40}));
        check("ir_afe_b", afe(rec[161]), 32'({1'b0, 1'b1, 4'd7, 7'd22}));
        check("ir_afe_after_gain_chg", afe(rec[190]), 32'({1'b0, 1'b1, 4'd7, 7'd22}));
        check("amb_afe", afe(rec[193]), 32'({1'b0, 1'b0, 4'd7, 7'd22}));
        check("amb_adc_start", 32'(rec[197].adc_start), 32'd1);
        check("smp_k137", smp(rec[137]), 32'({1'b1, 2'd0, 8'h54, 1'b0}));
        check("smp_k169", smp(rec[169]), 32'({1'b1, 2'd1, 8'h65, 1'b0}));
        check("smp_amb_k201", smp(rec[201]), 32'({1'b1, 2'd2, 8'h76, 1'b0}));
        check("red_new_gain", afe(rec[225]), 32'({1'b1, 1'b0, 4'd9, 7'd40}));

        // Output register: hold, coincident capture/accept, overrun
        check("smp_held_k231", smp(rec[231]), 32'({1'b1, 2'd2, 8'h76, 1'b0}));
        check("smp_coincide_k233", smp(rec[233]), 32'({1'b1, 2'd0, 8'h87, 1'b0}));
        check("smp_drop_k234", 32'(rec[234].valid), 32'd0);
        check("smp_k265", smp(rec[265]), 32'({1'b1, 2'd1, 8'h98, 1'b0}));
        check("smp_hold_k296", smp(rec[296]), 32'({1'b1, 2'd1, 8'h98, 1'b0}));
        check("smp_overrun_k297", smp(rec[297]), 32'({1'b1, 2'd2, 8'hA9, 1'b1}));
        check("smp_accept_k301", 32'({rec[301].valid, rec[301].overrun}), 32'b01);

        // ADC timeout, stray adc_done, fixed phase length
        check("tmo_adc_start", 32'(rec[325].adc_start), 32'd1);
        check("adc_err_k341", 32'(rec[341].adc_err), 32'd0);
        check("adc_err_k342", 32'(rec[342].adc_err), 32'd1);
        n_val = 0;
        for (int k = 321; k <= 353; k++) begin
            if (rec[k].valid) n_val++;
        end
        check("no_smp_on_tmo", 32'(n_val), 32'd0);
        check("ir_boundary_k352", 32'({rec[352].led_red, rec[352].led_ir}), 32'b10);
        check("ir_boundary_k353", 32'({rec[353].led_red, rec[353].led_ir}), 32'b01);

        // Reset mid-SETTLE of IR, then restart in RED
        check("midphase_reset", 32'(rec[355]), 32'd0);
        check("restart_setup", 32'({rec[357].busy, rec[357].led_red, rec[357].led_ir}), 32'b100);
        check("restart_red_afe", afe(rec[358]), 32'({1'b1, 1'b0, 4'd9, 7'd40}));
        check("restart_adc_start", 32'(rec[362].adc_start), 32'd1);
        check("restart_smp", smp(rec[366]), 32'({1'b1, 2'd0, 8'hBA, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppg_phase_scheduler.md
Name: ppg_phase_scheduler

Overview:
Time-division sampling scheduler for the PPG analog front-end. Once calibration has produced per-channel PGA gain and DC-compensation settings, this block takes over. It cycles RED, IR and an optional AMBIENT (both LEDs off) phase. In each phase it drives the LED enables and the front-end settings, waits for the analog path to settle, then runs one ADC conversion through a start/done handshake. Each result goes out as a tagged sample on a valid/ready interface to the downstream filter and SpO2 datapath.

Parameters:
SETTLE_CYC, 8, cycles from LED/setting change to ADC start (>=1)
PHASE_CYC, 64, total cycles per phase; must be >= SETTLE_CYC+ADC_TMO+4
ADC_TMO, 16, max cycles waiting for adc_done before a conversion is abandoned
DATA_W, 8, ADC sample width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run request; sampled only in IDLE and at phase boundaries
amb_en  in  1  include AMBIENT phase; sampled at frame start
red_gain  in  4  PGA gain for the RED phase
red_dc  in  7  DC compensation for the RED phase
ir_gain  in  4  PGA gain for the IR phase
ir_dc  in  7  DC compensation for the IR phase
led_red  out  1  RED LED enable
led_ir  out  1  IR LED enable
pga_gain  out  4  front-end PGA gain
dc_comp  out  7  front-end DC compensation code
adc_start  out  1  one-cycle conversion request
adc_done  in  1  conversion complete; adc_data valid this cycle
adc_data  in  DATA_W  conversion result
smp_valid  out  1  output sample valid
smp_chan  out  2  0=RED, 1=IR, 2=AMBIENT
smp_data  out  DATA_W  sample value
smp_ready  in  1  downstream accept
overrun  out  1  sticky: an unaccepted sample was overwritten
adc_err  out  1  sticky: an ADC timeout occurred
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; all counters clear.
  - Every output is 0: led_red, led_ir, pga_gain, dc_comp, adc_start, smp_valid, smp_chan, smp_data, overrun, adc_err, busy.
  - A reset mid-phase abandons the phase immediately and turns both LEDs off on that edge.
- States: IDLE, SETUP, SETTLE, CONVERT, HOLD. All outputs are registered.
- IDLE:
  - Both LEDs off; pga_gain and dc_comp hold their last values.
  - If enable=1: go to SETUP, with the phase set to RED.
- SETUP (1 cycle), entered at the start of every phase:
  - In the RED phase only, snapshot red_gain, red_dc, ir_gain, ir_dc and amb_en into shadow registers. A frame therefore never mixes settings.
  - Drive the outputs for the phase:
    - RED: led_red=1, led_ir=0, RED settings.
    - IR: led_ir=1, led_red=0, IR settings.
    - AMBIENT: both LEDs off; pga_gain and dc_comp keep the IR settings.
  - Clear the phase counter (phase_cnt); go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to CONVERT.
- CONVERT:
  - adc_start=1 on the first CONVERT cycle only.
  - Wait for adc_done. On adc_done, capture adc_data into smp_data and the phase into smp_chan; smp_valid=1 from the next cycle.
  - If adc_done has not arrived within ADC_TMO cycles of adc_start: set adc_err, emit no sample, go to HOLD.
  - An adc_done outside CONVERT is ignored.
- Output register (single entry):
  - smp_valid stays high until a cycle with smp_ready=1, then drops.
  - If a new capture happens while smp_valid=1 and smp_ready=0: overwrite the data and set overrun.
  - If capture and smp_ready=1 coincide in the same cycle: the new sample is loaded, smp_valid stays 1, and no overrun is flagged.
- HOLD:
  - Wait until phase_cnt = PHASE_CYC-1. phase_cnt counts from SETUP, so every phase is exactly PHASE_CYC cycles regardless of ADC latency.
  - Then select the next phase: RED -> IR; IR -> AMBIENT if the amb_en shadow is 1, else RED; AMBIENT -> RED.
  - If enable=0 at this boundary: go to IDLE with LEDs off. Otherwise go to SETUP.
- enable dropping mid-phase does not truncate the phase.
- overrun and adc_err clear only on reset.
- Counter widths are clog2-sized for their parameters; no wrap-around occurs within a phase.

Decomposition:
- Shared package pulse_pkg:
  - phase encoding: CH_RED=2'd0, CH_IR=2'd1, CH_AMB=2'd2
  - the state enum
  - GAIN_W=4, DC_W=7
- One natural sub-module, ppg_sample_reg: the single-entry valid/ready output register with overrun detection.
- The phase sequencer, settle/timeout counters and shadow registers stay in the top level.

Test Plan:
1. SETTLE_CYC=4, PHASE_CYC=32, ADC answers 3 cycles after adc_start, amb_en=0, enable held high.
   -> led_red for 32 cycles, then led_ir for 32, alternating.
   -> adc_start 5 cycles after each phase start.
   -> smp_chan sequence 0,1,0,1...
2. amb_en=1 with settings red=(5,40), ir=(7,22).
   -> RED, IR and AMBIENT phases of 32 cycles each.
   -> pga/dc read 5/40 in RED and 7/22 in IR and AMBIENT.
   -> AMBIENT sample tagged 2 with both LEDs off.
3. Change red_gain from 5 to 9 during an IR phase.
   -> pga_gain stays 5 until the next RED SETUP, then reads 9.
4. smp_ready tied 0 for two phases.
   -> Second capture overwrites smp_data and overrun=1.
   -> smp_ready pulse clears smp_valid; overrun stays 1.
5. adc_done never asserted, ADC_TMO=16.
   -> adc_err=1 and no smp_valid for that phase.
   -> Next phase starts exactly PHASE_CYC cycles after the previous SETUP.
6. rst_n low mid-SETTLE of an IR phase.
   -> Next edge: all outputs 0, state IDLE.
   -> With enable high after release, restart in RED.
